// File: rtl/uart_stim_pkg.sv
// Shared types and helpers for the UART stimulus transmitter.
package uart_stim_pkg;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  // PARITY parameter encodings.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Length of one frame in bit periods, or in clk cycles if clks_per_bit is given.
  function automatic int unsigned frame_clks(input int unsigned parity,
                                             input int unsigned stop_bits,
                                             input int unsigned clks_per_bit = 1);
    int unsigned nbits;
    nbits = 9 + stop_bits;
    if (parity != PAR_NONE) nbits = nbits + 1;
    return nbits * clks_per_bit;
  endfunction

  // Parity bit for a byte: even = XOR of the bits, odd = its inverse.
  function automatic logic parity_bit(input logic [7:0] b, input int unsigned parity);
    return (parity == PAR_ODD) ? ~(^b) : (^b);
  endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
module uart_stim_fifo
  import uart_stim_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer registers; one extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array; contents are left stale on reset since pointers gate all reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_stim_tx.sv
// UART transmitter fed from a byte FIFO; drives the bench's serial RX pad.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int unsigned        BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE    = BAUD_W'(1);
  localparam logic [2:0]         STOP_LAST   = 3'(STOP_BITS - 1);

  tx_state_e         state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        shreg, shreg_n;
  logic              par_q, par_n;
  logic              busy_q, busy_d;
  logic              tx_c;
  logic              pop;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_level;

  uart_stim_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_i),
    .pop   (pop),
    .din   (data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      busy_q   <= busy_d;
    end
  end

  // Next-state, line level and pop decision.
  // The end of STOP pops straight into START so back-to-back frames have no idle cycle.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_q;
    pop     = 1'b0;
    tx_c    = 1'b1;
    case (state)
      IDLE: begin
        tx_c = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_dout;
          par_n   = parity_bit(fifo_dout, PARITY);
          bit_n   = '0;
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end
      end
      START: begin
        tx_c = 1'b0;
        if (baud_cnt == '0) begin
          baud_n  = BAUD_RELOAD;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - BAUD_ONE;
        end
      end
      DATA: begin
        tx_c = shreg[0];
        if (baud_cnt == '0) begin
          baud_n  = BAUD_RELOAD;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_n   = '0;
            state_n = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt - BAUD_ONE;
        end
      end
      PAR: begin
        tx_c = par_q;
        if (baud_cnt == '0) begin
          baud_n  = BAUD_RELOAD;
          bit_n   = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt - BAUD_ONE;
        end
      end
      STOP: begin
        tx_c = 1'b1;
        if (baud_cnt == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_cnt == STOP_LAST) begin
            bit_n = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shreg_n = fifo_dout;
              par_n   = parity_bit(fifo_dout, PARITY);
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt - BAUD_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Busy looks ahead one cycle so it drops together with the return to IDLE.
  always_comb begin
    busy_d = (state_n != IDLE) | (valid_i & ~fifo_full) | (~fifo_empty & ~pop);
  end

  assign tx_o    = tx_c;
  assign busy_o  = busy_q;
  assign ready_o = ~fifo_full;
  assign level_o = fifo_level;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed self-checking bench for uart_stim_tx across four parameter sets.
module tb_uart_stim_tx;
  import uart_stim_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic       ready_a, ready_b, ready_c, ready_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic [4:0] level_a, level_b, level_c, level_d;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  uart_stim_tx dut_a (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid_a),
    .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .level_o(level_a)
  );

  uart_stim_tx #(.CLKS_PER_BIT(8), .PARITY(PAR_EVEN)) dut_b (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid_b),
    .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .level_o(level_b)
  );

  uart_stim_tx #(.CLKS_PER_BIT(8), .PARITY(PAR_ODD)) dut_c (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid_c),
    .ready_o(ready_c), .tx_o(tx_c), .busy_o(busy_c), .level_o(level_c)
  );

  uart_stim_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_d (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid_d),
    .ready_o(ready_d), .tx_o(tx_d), .busy_o(busy_d), .level_o(level_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic line_tx(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      2:       return tx_c;
      default: return tx_d;
    endcase
  endfunction

  function automatic logic line_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      2:       return busy_c;
      default: return busy_d;
    endcase
  endfunction

  // Called on the first cycle of a start bit; samples each bit mid-period and
  // returns exactly one frame later.
  task automatic capture(input int sel, input int cpb, input int nbits,
                         output logic [11:0] bits, output logic first_tx,
                         output logic last_tx, output logic last_busy);
    bits      = '0;
    first_tx  = line_tx(sel);
    last_tx   = 1'b0;
    last_busy = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      step(cpb / 2);
      bits[i] = line_tx(sel);
      if (i == nbits - 1) begin
        step(cpb - cpb / 2 - 1);
        last_tx   = line_tx(sel);
        last_busy = line_busy(sel);
        step(1);
      end else begin
        step(cpb - cpb / 2);
      end
    end
  endtask

  initial begin
    int unsigned bad;
    int unsigned bad_busy;
    int unsigned gaps;
    logic [9:0]  exp10;
    logic [11:0] bits;
    logic [11:0] expv;
    logic [7:0]  bv;
    logic        f_tx, l_tx, l_busy;

    rst = 1'b1; data = '0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
    step(3);
    rst = 1'b0;

    // Reset state of every instance
    chk("rst_tx_a",    32'(tx_a),    32'd1);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_busy_a",  32'(busy_a),  32'd0);
    chk("rst_level_a", 32'(level_a), 32'd0);
    chk("rst_tx_b",    32'(tx_b),    32'd1);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    chk("rst_busy_b",  32'(busy_b),  32'd0);
    chk("rst_level_b", 32'(level_b), 32'd0);
    chk("rst_tx_c",    32'(tx_c),    32'd1);
    chk("rst_ready_c", 32'(ready_c), 32'd1);
    chk("rst_busy_c",  32'(busy_c),  32'd0);
    chk("rst_level_c", 32'(level_c), 32'd0);
    chk("rst_tx_d",    32'(tx_d),    32'd1);
    chk("rst_ready_d", 32'(ready_d), 32'd1);
    chk("rst_busy_d",  32'(busy_d),  32'd0);
    chk("rst_level_d", 32'(level_d), 32'd0);

    // Idle line for 2000 cycles
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 5'd0) bad++;
    end
    chk("idle_quiet_cycles", bad, 32'd0);

    // Single 0x55 frame at 868 clks/bit, checked cycle by cycle
    data = 8'h55; valid_a = 1'b1;
    step(1);
    valid_a = 1'b0;
    chk("push_level",  32'(level_a), 32'd1);
    chk("push_busy",   32'(busy_a),  32'd1);
    chk("push_tx",     32'(tx_a),    32'd1);
    chk("push_ready",  32'(ready_a), 32'd1);
    step(1);
    chk("start_fall",  32'(tx_a),    32'd0);
    chk("pop_level",   32'(level_a), 32'd0);
    exp10 = 10'b1010101010;
    bad = 0; bad_busy = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 868; j++) begin
        if (tx_a !== exp10[i]) bad++;
        if (busy_a !== 1'b1) bad_busy++;
        step(1);
      end
    end
    chk("frame55_bit_cycles", bad, 32'd0);
    chk("frame55_busy_cycles", bad_busy, 32'd0);
    chk("frame55_busy_drop", 32'(busy_a), 32'd0);
    chk("frame55_tx_after",  32'(tx_a),   32'd1);

    // Overflow: one byte in flight, then 17 pushes; the 17th is dropped
    data = 8'hAA; valid_b = 1'b1;
    step(1);
    chk("burst_first_level", 32'(level_b), 32'd1);
    data = 8'h00;
    step(1);
    chk("burst_pushpop_level", 32'(level_b), 32'd1);
    chk("burst_start_fall",    32'(tx_b),    32'd0);
    for (int k = 1; k <= 16; k++) begin
      data = 8'(k);
      step(1);
      if (k == 14) begin
        chk("burst_l15_level", 32'(level_b), 32'd15);
        chk("burst_l15_ready", 32'(ready_b), 32'd1);
      end
      if (k == 15) begin
        chk("burst_full_level", 32'(level_b), 32'd16);
        chk("burst_full_ready", 32'(ready_b), 32'd0);
      end
    end
    valid_b = 1'b0;
    chk("burst_drop_level", 32'(level_b), 32'd16);
    // 0xAA frame began 16 cycles ago; 88-cycle frames
    step(72);
    gaps = 0;
    for (int f = 0; f < 16; f++) begin
      bv   = 8'(f);
      expv = {1'b0, 1'b1, ^bv, bv, 1'b0};
      capture(1, 8, 11, bits, f_tx, l_tx, l_busy);
      if (f_tx !== 1'b0) gaps++;
      chk("burst_frame", 32'(bits), 32'(expv));
    end
    chk("burst_no_gap", gaps, 32'd0);
    chk("burst_last_busy", 32'(l_busy), 32'd1);
    chk("burst_end_busy",  32'(busy_b), 32'd0);
    chk("burst_end_level", 32'(level_b), 32'd0);
    chk("burst_end_tx",    32'(tx_b),   32'd1);

    // Odd parity with 0x07 -> parity bit 0
    data = 8'h07; valid_c = 1'b1;
    step(1);
    valid_c = 1'b0;
    step(1);
    capture(2, 8, 11, bits, f_tx, l_tx, l_busy);
    chk("odd_start",      32'(f_tx),   32'd0);
    chk("odd_frame",      32'(bits),   32'h40E);
    chk("odd_last_busy",  32'(l_busy), 32'd1);
    chk("odd_end_busy",   32'(busy_c), 32'd0);

    // Even parity with 0x07 -> parity bit 1
    data = 8'h07; valid_b = 1'b1;
    step(1);
    valid_b = 1'b0;
    step(1);
    capture(1, 8, 11, bits, f_tx, l_tx, l_busy);
    chk("even_start",     32'(f_tx),   32'd0);
    chk("even_frame",     32'(bits),   32'h60E);
    chk("even_last_busy", 32'(l_busy), 32'd1);
    chk("even_end_busy",  32'(busy_b), 32'd0);

    // Two stop bits, 4 clks/bit: second start 44 cycles after the first
    data = 8'hA5; valid_d = 1'b1;
    step(1);
    data = 8'h3C;
    step(1);
    valid_d = 1'b0;
    chk("stop2_start1", 32'(tx_d), 32'd0);
    capture(3, 4, 11, bits, f_tx, l_tx, l_busy);
    chk("stop2_frame1",   32'(bits), 32'h74A);
    chk("stop2_last_stop", 32'(l_tx), 32'd1);
    chk("stop2_start2_at44", 32'(tx_d), 32'd0);
    capture(3, 4, 11, bits, f_tx, l_tx, l_busy);
    chk("stop2_frame2",   32'(bits), 32'h678);
    chk("stop2_end_busy", 32'(busy_d), 32'd0);
    chk("stop2_end_level", 32'(level_d), 32'd0);

    // Reset during DATA bit 3 of 0x11 with 3 more bytes queued
    data = 8'h11; valid_a = 1'b1;
    step(1);
    data = 8'h22;
    step(1);
    data = 8'h33;
    step(1);
    data = 8'h44;
    step(1);
    valid_a = 1'b0;
    step(3904);
    chk("abort_pre_tx",    32'(tx_a),    32'd0);
    chk("abort_pre_level", 32'(level_a), 32'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_tx",    32'(tx_a),    32'd1);
    chk("abort_level", 32'(level_a), 32'd0);
    chk("abort_busy",  32'(busy_a),  32'd0);
    chk("abort_ready", 32'(ready_a), 32'd1);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 5'd0) bad++;
    end
    chk("abort_quiet_cycles", bad, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
